// File: rtl/dmem_lsu.sv
// Load/store unit that drives the data-memory port for one core request at a time.
// LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of forcing their low address bits to zero.
module dmem_lsu #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_cause,
    output logic [1:0]        dmemRW,
    output logic [3:0]        w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    input  logic              mem_outofbound
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

    state_t      state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [2:0]  wait_cnt;

    logic        illegal;
    logic        trap;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] din;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misal;
`endif

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_ext = 32'(b);
            3'b001:  load_ext = 32'(h);
            3'b100:  load_ext = {24'b0, b};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = word;
        endcase
    endfunction

    // Request decode: legality, effective lane (low bits dropped for misaligned sizes), store lanes
    always_comb begin
        illegal = req_store ? (req_funct3 > 3'b010)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b00: begin
                lane = req_addr[1:0];
                be   = 4'b0001 << lane;
                din  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane = {req_addr[1], 1'b0};
                be   = 4'b0011 << lane;
                din  = {2{req_wdata[15:0]}};
            end
            default: begin
                lane = 2'b00;
                be   = 4'b1111;
                din  = req_wdata;
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        trap  = illegal | misal;
`else
        trap  = illegal;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_cause <= 2'b00;
            dmemRW     <= 2'b00;
            w_en       <= 4'b0000;
            mem_addr   <= '0;
            mem_din    <= '0;
            st_q       <= 1'b0;
            f3_q       <= 3'b000;
            lane_q     <= 2'b00;
            wait_cnt   <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        st_q      <= req_store;
                        f3_q      <= req_funct3;
                        lane_q    <= lane;
                        if (trap) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_cause <= illegal ? 2'b11 : 2'b01;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ISSUE;
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_store) begin
                                dmemRW  <= 2'b01;
                                w_en    <= be;
                                mem_din <= din;
                            end else begin
                                dmemRW  <= 2'b10;
                                w_en    <= 4'b0000;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (st_q) begin
                        state      <= RESP;
                        dmemRW     <= 2'b00;
                        w_en       <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_outofbound;
                        resp_cause <= mem_outofbound ? 2'b10 : 2'b00;
                        resp_rdata <= '0;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LAST;
                    end
                end
                // Read command stays on the port until the last latency cycle captures the data
                WAIT: begin
                    if (wait_cnt == 3'b000) begin
                        state      <= RESP;
                        dmemRW     <= 2'b00;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_outofbound;
                        resp_cause <= mem_outofbound ? 2'b10 : 2'b00;
                        resp_rdata <= mem_outofbound ? 32'b0 : load_ext(mem_dout, f3_q, lane_q);
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP, ERR: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_cause <= 2'b00;
                        resp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed cases plus randomized requests against a behavioural model.
module tb_dmem_lsu;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic [1:0]  dmemRW;
    logic [3:0]  w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = '0;
    logic        mem_outofbound = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_cause(resp_cause),
        .dmemRW(dmemRW), .w_en(w_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_outofbound(mem_outofbound)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request through to its response, checked against expectations derived from the ISA rules
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] dout, input logic oob,
                           input int hold);
        logic        illegal, misal, trap;
        int          nb, lane, e_lat, lat, ncmd;
        logic [31:0] mask, data, e_addr, e_din, e_rdata, c_addr, c_din;
        logic [3:0]  e_wen, c_wen;
        logic [1:0]  e_rw, c_rw, e_cause;
        logic        e_err;

        nb      = 1 << f3[1:0];
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misal   = (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = illegal || misal;
`else
        trap = illegal;
`endif
        lane   = (nb >= 4) ? 0 : int'(addr % 4) / nb * nb;
        mask   = (nb >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        e_addr = addr - addr % 4;
        e_din  = '0;
        e_wen  = '0;
        if (trap) begin
            e_lat = 0; e_rw = 2'd0; e_err = 1'b1; e_cause = illegal ? 2'd3 : 2'd1; e_rdata = '0;
        end else if (st) begin
            e_lat   = 1;
            e_rw    = 2'd1;
            e_wen   = 4'(((1 << nb) - 1) << lane);
            e_din   = (nb == 1) ? {24'b0, wd[7:0]} * 32'h0101_0101 :
                      (nb == 2) ? {16'b0, wd[15:0]} * 32'h0001_0001 : wd;
            e_rdata = '0;
            e_err   = oob;
            e_cause = oob ? 2'd2 : 2'd0;
        end else begin
            e_lat = 1 + RD_LAT;
            e_rw  = 2'd2;
            data  = (dout >> (8 * lane)) & mask;
            if (!f3[2] && nb < 4 && data[8*nb-1]) data = data | ~mask;
            e_rdata = oob ? 32'b0 : data;
            e_err   = oob;
            e_cause = oob ? 2'd2 : 2'd0;
        end

        req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_dout = dout; mem_outofbound = oob; req_valid = 1'b1;
        check("req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;

        lat = 0; ncmd = 0;
        c_rw = '0; c_wen = '0; c_addr = '0; c_din = '0;
        while (!resp_valid && lat < 20) begin
            if (dmemRW != 2'b00) begin
                if (ncmd == 0) begin
                    c_rw = dmemRW; c_wen = w_en; c_addr = mem_addr; c_din = mem_din;
                end
                ncmd++;
            end
            tick();
            lat++;
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("cmd_cycles", 32'(ncmd), 32'(e_lat));
        if (!trap) begin
            check("dmemRW", 32'(c_rw), 32'(e_rw));
            check("mem_addr", c_addr, e_addr);
            check("w_en", 32'(c_wen), 32'(e_wen));
            if (st) check("mem_din", c_din, e_din);
        end
        check("rdata", resp_rdata, e_rdata);
        check("err", 32'(resp_err), 32'(e_err));
        check("cause", 32'(resp_cause), 32'(e_cause));

        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, e_rdata);
            check("hold_cause", 32'(resp_cause), 32'(e_cause));
            check("hold_idle_port", 32'({dmemRW, w_en}), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_1000;
        tick();
        tick();
        check("rst_dmemRW", 32'(dmemRW), 32'd0);
        check("rst_w_en", 32'(w_en), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        tick();

        run_txn(1'b1, 3'b000, 32'h8000_0003, 32'h2022_1118, 32'h0, 1'b0, 0);
        run_txn(1'b0, 3'b001, 32'h0010_0002, 32'h0, 32'h1198_7251, 1'b0, 1);
        run_txn(1'b0, 3'b000, 32'h0010_0000, 32'h0, 32'h1879_0485, 1'b0, 0);
        run_txn(1'b0, 3'b100, 32'h0010_0000, 32'h0, 32'h1879_0485, 1'b0, 0);
        run_txn(1'b0, 3'b010, 32'h0010_0006, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'h0, 1'b0, 0);
        run_txn(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b1, 2);
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 1'b1, 4);
        run_txn(1'b1, 3'b011, 32'h0000_0100, 32'h1, 32'h0, 1'b0, 1);
        run_txn(1'b0, 3'b110, 32'h0000_0101, 32'h0, 32'h0, 1'b0, 0);
        run_txn(1'b0, 3'b101, 32'h0000_0003, 32'h0, 32'h8001_7FFF, 1'b0, 0);

        // Reset pulsed while a load waits on memory
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0200; req_valid = 1'b1;
        mem_outofbound = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("abort_dmemRW", 32'(dmemRW), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        check("abort_port_idle", 32'({dmemRW, w_en}), 32'd0);

        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, $urandom,
                    ($urandom % 4) == 0, int'($urandom % 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that drives the data-memory port (2-bit RW command, 4-bit byte write enables, 32-bit address and data) on behalf of the core.
- Accepts one RISC-V style load/store request at a time over a valid/ready handshake.
- Issues a word-aligned memory command with lane-shifted write data; extracts and sign- or zero-extends read data.
- Returns a registered response with error status. Sits between the execute stage and dmem.

Parameters:
- RD_LAT, 1: dmem read latency in cycles, range 1..7.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access failed
- resp_cause  out  2  01 misaligned, 10 out of bound, 11 illegal op, 00 none
- dmemRW  out  2  01 write, 10 read, 00 idle; 11 never driven
- w_en  out  4  byte write enables; 0000 unless writing
- mem_addr  out  ADDR_W  word-aligned address; low 2 bits always 00
- mem_din  out  32  lane-aligned write data
- mem_dout  in  32  dmem read data
- mem_outofbound  in  1  dmem out-of-bound flag

Behaviour:
- All outputs are registered. Reset clears asynchronously:
  - state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_cause=00
  - dmemRW=00, w_en=0000, mem_addr=0, mem_din=0
- Reset asserted mid-access aborts the access; no partial response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch the request.
  - Illegal op (load funct3 011/110/111; store funct3 other than 000/001/010) -> ERR with cause 11.
  - Misaligned access (see Optional Feature) -> ERR with cause 01.
  - Otherwise -> ISSUE.
  - req_ready=0 in every other state.
- ISSUE (exactly 1 cycle), driving mem_addr={addr[31:2],00}:
  - Store: dmemRW=01; w_en = sb 0001<<addr[1:0], sh 0011<<{addr[1],0}, sw 1111.
  - Store: mem_din = wdata[7:0] replicated x4 (sb), wdata[15:0] replicated x2 (sh), wdata (sw).
  - Store: mem_outofbound is sampled at the end of ISSUE, then -> RESP.
  - Load: dmemRW=10, w_en=0000, then -> WAIT.
- WAIT (load only):
  - Command and address held for RD_LAT cycles.
  - On the final edge, capture mem_dout and mem_outofbound, then -> RESP.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - lb/lh: sign-extend. lbu/lhu: zero-extend. lw: full word.
- RESP:
  - dmemRW=00, w_en=0000.
  - resp_valid=1; resp_err=mem_outofbound; cause 10 if set.
  - resp_rdata is 0 if err or store.
  - Held stable until resp_ready=1, then -> IDLE on that edge.
  - Next request accepted no earlier than the following cycle.
- ERR:
  - No memory command issued; behaves as RESP with resp_err=1, rdata=0.
- Throughput:
  - Store: 3 cycles minimum, accept to IDLE.
  - Load: 3+RD_LAT cycles minimum.
- Illegal op takes priority over misaligned.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=00, goes to ERR, cause 01.
  - No dmem command is issued.
- Undefined:
  - Offending low bits are forced to zero (halfword uses addr[1]; word uses lane 0).
  - The access proceeds normally; resp_err reflects only out-of-bound and illegal-op conditions.

Test Plan:
- Reset low with req_valid=1 -> dmemRW=00, w_en=0000, resp_valid=0, req_ready=1; then release reset.
- sb, addr 0x80000003, wdata 0x20221118 -> ISSUE shows dmemRW=01, w_en=1000, mem_addr=0x80000000, mem_din=0x18181818; resp_err=0.
- lh, addr 0x00100002, mem_dout=0x11987251 -> rdata=0x00001198 after 3+RD_LAT cycles.
- lb, addr 0x00100000, mem_dout=0x18790485 -> rdata=0xFFFFFF85; lbu -> 0x00000085.
- lw, addr 0x00100006 with LSU_MISALIGN_TRAP_EN -> no dmemRW pulse, resp_err=1, cause 01. Without the macro -> mem_addr=0x00100004, normal read.
- Load with mem_outofbound=1 at capture -> resp_err=1, cause 10, rdata=0. resp_ready held low 4 cycles -> response stable. Reset pulsed during WAIT -> IDLE, no resp_valid.
